// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces key events, edits a hex entry buffer, scans it onto the display.
// Optional build macro KEYPAD_AUTOREPEAT_EN re-applies held digit/backspace actions every REPEAT_CYCLES.
module keypad_entry_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int HOLD_CYCLES   = 1000,
  parameter int SCAN_DIV      = 100000,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_pressed,
  input  logic [3:0]                        key_code,
  output logic [4*NUM_DIGITS-1:0]           entry_value,
  output logic                              entry_valid,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              overflow,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [3:0]                        seg_digit
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int DW = $clog2(SCAN_DIV);

  localparam logic [CW-1:0] FULL      = CW'(NUM_DIGITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    ACT,
    WAIT_RELEASE
  } state_t;

  state_t          state, state_next;
  logic [HW-1:0]   cnt, cnt_next;
  logic            capture;
  logic [3:0]      code_reg;
  logic [BW-1:0]   buffer;
  logic            rep_fire;
  logic            do_action;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   slot;
  logic [NUM_DIGITS-1:0] an_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      code_reg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) code_reg <= key_code;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (key_pressed) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end
      DEBOUNCE: begin
        if (!key_pressed) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == HOLD_LAST) begin
          capture    = 1'b1;
          state_next = ACT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ACT: begin
        state_next = WAIT_RELEASE;
        cnt_next   = '0;
      end
      WAIT_RELEASE: begin
        if (key_pressed) begin
          cnt_next = '0;
        end else if (cnt == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  // Enter and clear are one-shot; only digits and backspace repeat.
  assign rep_fire = (state == WAIT_RELEASE) && key_pressed &&
                    (rep_cnt == REP_LAST) && (code_reg <= 4'hD);

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_RELEASE || !key_pressed) rep_cnt <= '0;
    else if (rep_cnt == REP_LAST)                     rep_cnt <= '0;
    else                                              rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign do_action = (state == ACT) || rep_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer      <= '0;
      digit_count <= '0;
      overflow    <= 1'b0;
      entry_value <= '0;
      entry_valid <= 1'b0;
    end else begin
      entry_valid <= 1'b0;
      if (do_action) begin
        case (code_reg)
          4'hD: begin
            if (digit_count != '0) begin
              buffer      <= buffer >> 4;
              digit_count <= digit_count - 1'b1;
            end
          end
          4'hE: begin
            entry_value <= buffer;
            entry_valid <= 1'b1;
            buffer      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
          end
          4'hF: begin
            buffer      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
          end
          default: begin
            if (digit_count < FULL) begin
              buffer      <= {buffer[BW-5:0], code_reg};
              digit_count <= digit_count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Slots at or beyond digit_count stay dark so leading positions are blank.
  always_comb begin
    an_next = '1;
    if (CW'(slot) < digit_count) an_next[slot] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      slot      <= '0;
      an        <= '1;
      seg_digit <= '0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        slot    <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      an        <= an_next;
      seg_digit <= buffer[4*slot +: 4];
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl; committed values are scoreboarded through a queue.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic [2:0]  digit_count;
  logic        overflow;
  logic [3:0]  an;
  logic [3:0]  seg_digit;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pulses = 0;
  logic [15:0] exp_q[$];
  logic        prev_valid = 1'b0;

  keypad_entry_ctrl #(
    .NUM_DIGITS(4),
    .HOLD_CYCLES(4),
    .SCAN_DIV(8),
    .REPEAT_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_pressed(key_pressed),
    .key_code(key_code),
    .entry_value(entry_value),
    .entry_valid(entry_valid),
    .digit_count(digit_count),
    .overflow(overflow),
    .an(an),
    .seg_digit(seg_digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: each commit pulse must match the oldest queued Enter.
  always @(negedge clk) begin
    if (entry_valid) begin
      n_pulses++;
      check("valid_width", {31'b0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
      else                   check("entry_value", {16'b0, entry_value}, {16'b0, exp_q.pop_front()});
    end
    prev_valid = entry_valid;
  end

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    key_pressed = 1'b1;
    key_code    = code;
    repeat (hold) @(negedge clk);
    key_pressed = 1'b0;
    key_code    = 4'h0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic scan_check(input logic [15:0] buf_e, input int cnt_e);
    bit          seen [4];
    int          blank;
    int          zeros;
    int          idx;
    logic [15:0] tmp;
    blank = 0;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (an != 4'b1111) begin
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin zeros++; idx = i; end
        check("an_onehot", zeros, 32'd1);
        check("an_slot_lit", {31'b0, idx < cnt_e}, 32'd1);
        tmp = buf_e >> (4 * idx);
        check("seg_digit", {28'b0, seg_digit}, {28'b0, tmp[3:0]});
        seen[idx] = 1'b1;
      end else begin
        blank++;
      end
    end
    for (int i = 0; i < cnt_e; i++) check("slot_seen", {31'b0, seen[i]}, 32'd1);
    if (cnt_e < 4) check("blank_slot", {31'b0, blank > 0}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},    {29'b0, digit_count}, 32'd0);
    check({tag, "_an"},       {28'b0, an},          32'hF);
    check({tag, "_seg"},      {28'b0, seg_digit},   32'd0);
    check({tag, "_overflow"}, {31'b0, overflow},    32'd0);
    check({tag, "_value"},    {16'b0, entry_value}, 32'd0);
    check({tag, "_valid"},    {31'b0, entry_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] hold_buf;
    int          hold_cnt;
    logic        hold_ovf;

    rst         = 1'b1;
    key_pressed = 1'b1;
    key_code    = 4'h5;
    @(negedge clk);
    // 1: reset with key held, then release -> nothing accepted
    repeat (3) @(negedge clk);
    rst         = 1'b0;
    key_pressed = 1'b0;
    check_reset_outputs("rst1");
    repeat (12) @(negedge clk);
    check("idle_count", {29'b0, digit_count}, 32'd0);
    check("idle_an", {28'b0, an}, 32'hF);

    // 2: three digits
    press(4'h1, 10, 10);
    press(4'h2, 10, 10);
    press(4'h3, 10, 10);
    check("three_count", {29'b0, digit_count}, 32'd3);
    scan_check(16'h0123, 3);

    // 3: enter commits and clears
    exp_q.push_back(16'h0123);
    press(4'hE, 10, 10);
    check("enter_count", {29'b0, digit_count}, 32'd0);
    check("enter_value", {16'b0, entry_value}, 32'h0123);
    scan_check(16'h0000, 0);

    // 4: overflow, backspace, clear
    for (int d = 1; d <= 5; d++) press(4'(d), 10, 10);
    check("full_count", {29'b0, digit_count}, 32'd4);
    check("full_overflow", {31'b0, overflow}, 32'd1);
    scan_check(16'h1234, 4);
    press(4'hD, 10, 10);
    check("bs_count", {29'b0, digit_count}, 32'd3);
    check("bs_overflow", {31'b0, overflow}, 32'd1);
    scan_check(16'h0123, 3);
    press(4'hF, 10, 10);
    check("clr_count", {29'b0, digit_count}, 32'd0);
    check("clr_overflow", {31'b0, overflow}, 32'd0);
    check("clr_value", {16'b0, entry_value}, 32'h0123);

    // 5: long hold
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_buf = 16'h7777; hold_cnt = 4; hold_ovf = 1'b1;
`else
    hold_buf = 16'h0007; hold_cnt = 1; hold_ovf = 1'b0;
`endif
    press(4'h7, 100, 10);
    check("hold_count", {29'b0, digit_count}, hold_cnt);
    check("hold_overflow", {31'b0, overflow}, {31'b0, hold_ovf});
    scan_check(hold_buf, hold_cnt);
    exp_q.push_back(hold_buf);
    press(4'hE, 10, 10);
    check("hold_commit", {16'b0, entry_value}, {16'b0, hold_buf});

    // 6: reset during WAIT_RELEASE with key still held
    key_pressed = 1'b1;
    key_code    = 4'h9;
    repeat (8) @(negedge clk);
    check("pre_rst_count", {29'b0, digit_count}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst2");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rehold_early", {29'b0, digit_count}, 32'd0);
    repeat (4) @(negedge clk);
    check("rehold_count", {29'b0, digit_count}, 32'd1);
    key_pressed = 1'b0;
    repeat (10) @(negedge clk);
    scan_check(16'h0009, 1);

    check("pulse_total", n_pulses, 32'd2);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
